// File: rtl/prbs_pkg.sv
// Shared constants and FSM state type for the PRBS31 packet generator.
// The PRBS parameters must match the checker so both ends run the same sequence.
package prbs_pkg;

    localparam int PRBS_POLY_LEN = 31;
    localparam int PRBS_POLY_TAP = 28;
    localparam int PRBS_NBITS    = 32;
    localparam int PRBS_INV      = 1;

    localparam logic [1:0] VLDB_FULL = 2'b11;

    typedef enum logic [1:0] {
        ST_PRIME,
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } pkt_state_e;

endpackage

// File: rtl/gtwizard_ultrascale_0_prbs_any.sv
// Parallel PRBS generator/checker core: NBITS of the LFSR sequence per enabled cycle.
// Bit 0 of DATA_OUT is the oldest bit of the word; the reset is asynchronous.
module gtwizard_ultrascale_0_prbs_any #(
    parameter int CHK_MODE    = 0,
    parameter int INV_PATTERN = 0,
    parameter int POLY_LENGHT = 31,
    parameter int POLY_TAP    = 3,
    parameter int NBITS       = 16
) (
    input  logic             RST,
    input  logic             CLK,
    input  logic [NBITS-1:0] DATA_IN,
    input  logic             EN,
    output logic [NBITS-1:0] DATA_OUT
);

    logic [POLY_LENGHT:1] prbs_q;
    logic [POLY_LENGHT:1] prbs_d;
    logic [POLY_LENGHT:1] lfsr;
    logic [NBITS-1:0]     data_d;
    logic [NBITS-1:0]     data_in_i;
    logic                 fb;
    logic                 msb;

    assign data_in_i = (INV_PATTERN != 0) ? ~DATA_IN : DATA_IN;

    // Position 1 of the LFSR holds the newest bit, position POLY_LENGHT the oldest.
    always_comb begin
        lfsr   = prbs_q;
        data_d = '0;
        fb     = 1'b0;
        msb    = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            fb        = lfsr[POLY_TAP] ^ lfsr[POLY_LENGHT];
            data_d[i] = fb ^ data_in_i[i];
            msb       = (CHK_MODE == 0) ? fb : data_in_i[i];
            lfsr      = {lfsr[POLY_LENGHT-1:1], msb};
        end
        prbs_d = lfsr;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prbs_q   <= '1;
            DATA_OUT <= '1;
        end else if (EN) begin
            prbs_q   <= prbs_d;
            DATA_OUT <= data_d;
        end
    end

endmodule

// File: rtl/prbs_pkt_gen.sv
// Transmit-side PRBS31 packet source: fixed-length packets on a 32-bit valid/ready stream.
// The PRBS sequence runs across packet boundaries and advances once per load event.
module prbs_pkt_gen
    import prbs_pkg::*;
#(
    parameter int PKT_WORDS = 256,
    parameter int IDLE_GAP  = 4
) (
    input  logic        tx_user_clk_i,
    input  logic        tx_user_rst_n_i,
    input  logic        en_i,
    input  logic        err_inject_i,
    input  logic        tx_ready_i,
    output logic [31:0] tx_data_o,
    output logic [1:0]  tx_vldb_o,
    output logic        tx_valid_o,
    output logic        tx_last_o,
    output logic        tx_user_o,
    output logic [31:0] pkt_cnt_o
);

    localparam logic [7:0] LAST_BEAT = 8'(PKT_WORDS - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(IDLE_GAP - 1);
    localparam logic [PRBS_NBITS-1:0] PRBS_SEED_IN = '0;

    pkt_state_e            state_q;
    logic [7:0]            beat_cnt_q;
    logic [7:0]            gap_cnt_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  user_q;
    logic [1:0]            vldb_q;
    logic [31:0]           pkt_cnt_q;
    logic                  inj_pend_q;
    logic                  inj_pend_d;
    logic                  inj_cur_q;
    logic                  acc;
    logic                  load;
    logic                  prbs_rst;
    logic [PRBS_NBITS-1:0] prbs_word;

    assign acc      = valid_q & tx_ready_i;
    assign load     = (state_q == ST_PRIME) | acc;
    assign prbs_rst = ~tx_user_rst_n_i;

    gtwizard_ultrascale_0_prbs_any #(
        .CHK_MODE    (0),
        .INV_PATTERN (PRBS_INV),
        .POLY_LENGHT (PRBS_POLY_LEN),
        .POLY_TAP    (PRBS_POLY_TAP),
        .NBITS       (PRBS_NBITS)
    ) u_prbs (
        .RST      (prbs_rst),
        .CLK      (tx_user_clk_i),
        .DATA_IN  (PRBS_SEED_IN),
        .EN       (load),
        .DATA_OUT (prbs_word)
    );

    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            state_q    <= ST_PRIME;
            beat_cnt_q <= '0;
            gap_cnt_q  <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            user_q     <= 1'b0;
            vldb_q     <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_PRIME: state_q <= ST_IDLE;
                ST_IDLE: begin
                    if (en_i) begin
                        state_q    <= ST_SEND;
                        beat_cnt_q <= '0;
                        valid_q    <= 1'b1;
                        vldb_q     <= VLDB_FULL;
                        user_q     <= 1'b1;
                        last_q     <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (acc) begin
                        if (last_q) begin
                            pkt_cnt_q <= pkt_cnt_q + 32'd1;
                            if (IDLE_GAP > 0) begin
                                state_q   <= ST_GAP;
                                gap_cnt_q <= GAP_LOAD;
                                valid_q   <= 1'b0;
                                vldb_q    <= '0;
                                user_q    <= 1'b0;
                                last_q    <= 1'b0;
                            end else if (en_i) begin
                                beat_cnt_q <= '0;
                                user_q     <= 1'b1;
                                last_q     <= 1'b0;
                            end else begin
                                state_q <= ST_IDLE;
                                valid_q <= 1'b0;
                                vldb_q  <= '0;
                                user_q  <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                            last_q     <= ((beat_cnt_q + 8'd1) == LAST_BEAT);
                            user_q     <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    // The final gap cycle doubles as the en_i decision point.
                    if (gap_cnt_q == 8'd0) begin
                        if (en_i) begin
                            state_q    <= ST_SEND;
                            beat_cnt_q <= '0;
                            valid_q    <= 1'b1;
                            vldb_q     <= VLDB_FULL;
                            user_q     <= 1'b1;
                            last_q     <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= ST_PRIME;
            endcase
        end
    end

    // A pulse arriving while one is already pending merges into it.
    always_comb begin
        inj_pend_d = inj_pend_q | err_inject_i;
        if (load) begin
            inj_pend_d = err_inject_i & ~inj_pend_q;
        end
    end

    always_ff @(posedge tx_user_clk_i or negedge tx_user_rst_n_i) begin
        if (!tx_user_rst_n_i) begin
            inj_pend_q <= 1'b0;
            inj_cur_q  <= 1'b0;
        end else begin
            inj_pend_q <= inj_pend_d;
            if (load) begin
                inj_cur_q <= inj_pend_q;
            end
        end
    end

    assign tx_data_o  = (state_q == ST_PRIME) ? '0 : (prbs_word ^ {31'b0, inj_cur_q});
    assign tx_vldb_o  = vldb_q;
    assign tx_valid_o = valid_q;
    assign tx_last_o  = last_q;
    assign tx_user_o  = user_q;
    assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_prbs_pkt_gen.sv
// Bench for prbs_pkt_gen: two instances (256 beats / gap 4 and 2 beats / gap 0) checked
// every cycle against a stream-level model built from the PRBS31 bit recurrence.
module tb_prbs_pkt_gen;

    localparam int NINST  = 2;
    localparam int NWORDS = 16384;

    logic clk    = 1'b0;
    logic rstN   = 1'b1;
    logic en     = 1'b0;
    logic errInj = 1'b0;
    logic ready  = 1'b0;

    logic [31:0] dataO   [NINST];
    logic [1:0]  vldbO   [NINST];
    logic        validO  [NINST];
    logic        lastO   [NINST];
    logic        userO   [NINST];
    logic [31:0] pktCntO [NINST];

    int nCompared = 0;
    int nFailed   = 0;
    logic [31:0] prbsWord [NWORDS];
    logic [31:0] pktBefore;

    always #5 clk = ~clk;

    task automatic checkOutput(input int inst, input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s inst%0d @%0t: got %h expected %h", name, inst, $time, got, exp);
        end
    endtask

    // Bit stream s[n] = s[n-28] ^ s[n-31] seeded with 31 ones; word k bit i is ~s[32k+i].
    function automatic void buildPrbs();
        logic [30:0] hist;
        logic [31:0] w;
        logic        b;
        hist = '1;
        w    = '0;
        for (int k = 0; k < NWORDS; k++) begin
            for (int i = 0; i < 32; i++) begin
                b    = hist[27] ^ hist[30];
                w[i] = ~b;
                hist = {hist[29:0], b};
            end
            prbsWord[k] = w;
        end
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : inst
        localparam int W = (g == 0) ? 256 : 2;
        localparam int G = (g == 0) ? 4 : 0;

        prbs_pkt_gen #(
            .PKT_WORDS (W),
            .IDLE_GAP  (G)
        ) dut (
            .tx_user_clk_i   (clk),
            .tx_user_rst_n_i (rstN),
            .en_i            (en),
            .err_inject_i    (errInj),
            .tx_ready_i      (ready),
            .tx_data_o       (dataO[g]),
            .tx_vldb_o       (vldbO[g]),
            .tx_valid_o      (validO[g]),
            .tx_last_o       (lastO[g]),
            .tx_user_o       (userO[g]),
            .pkt_cnt_o       (pktCntO[g])
        );

        bit          flip [NWORDS];
        bit          mPrimed, mInPkt, mPend, mAcc, mPrime;
        int          mWord, mBeat, mStartFrom, mCyc, loadIdx;
        logic [31:0] mPkt;
        bit          armed;
        int          lowRun;

        // Model: word index = accepted beats since reset; packets restart no earlier than G cycles after a last.
        always @(negedge clk) begin
            if (!rstN) begin
                checkOutput(g, "rst_valid", 32'(validO[g]), 32'd0);
                checkOutput(g, "rst_vldb", 32'(vldbO[g]), 32'd0);
                checkOutput(g, "rst_last", 32'(lastO[g]), 32'd0);
                checkOutput(g, "rst_user", 32'(userO[g]), 32'd0);
                checkOutput(g, "rst_pkt_cnt", pktCntO[g], 32'd0);
                checkOutput(g, "rst_data", dataO[g], 32'd0);
                mPrimed    = 1'b0;
                mInPkt     = 1'b0;
                mPend      = 1'b0;
                mWord      = 0;
                mBeat      = 0;
                mStartFrom = 0;
                mCyc       = 0;
                mPkt       = '0;
            end else begin
                if (!mPrimed) begin
                    checkOutput(g, "prime_data", dataO[g], 32'd0);
                end else if (mInPkt) begin
                    checkOutput(g, "data", dataO[g], prbsWord[mWord] ^ 32'(flip[mWord]));
                end
                checkOutput(g, "valid", 32'(validO[g]), 32'(mInPkt));
                checkOutput(g, "vldb", 32'(vldbO[g]), mInPkt ? 32'd3 : 32'd0);
                checkOutput(g, "last", 32'(lastO[g]), 32'(mInPkt && (mBeat == W - 1)));
                checkOutput(g, "user", 32'(userO[g]), 32'(mInPkt && (mBeat == 0)));
                checkOutput(g, "pkt_cnt", pktCntO[g], mPkt);

                mAcc   = mInPkt && (ready === 1'b1);
                mPrime = !mPrimed;
                if (mPrime || mAcc) begin
                    loadIdx       = mPrime ? 0 : mWord + 1;
                    flip[loadIdx] = mPend;
                    mPend         = (errInj === 1'b1) && !mPend;
                end else begin
                    mPend = mPend || (errInj === 1'b1);
                end
                if (mPrime) begin
                    mPrimed    = 1'b1;
                    mStartFrom = mCyc + 1;
                end
                if (mAcc) begin
                    mWord++;
                    if (mWord >= NWORDS - 2) begin
                        $display("[TB] FAIL word_budget inst%0d: got %0d expected below %0d", g, mWord, NWORDS - 2);
                        $fatal(1);
                    end
                    if (mBeat == W - 1) begin
                        mPkt       = mPkt + 32'd1;
                        mInPkt     = 1'b0;
                        mStartFrom = mCyc + G;
                    end else begin
                        mBeat++;
                    end
                end
                if (!mInPkt && mPrimed && (mCyc >= mStartFrom) && (en === 1'b1)) begin
                    mInPkt = 1'b1;
                    mBeat  = 0;
                end
                mCyc++;
            end
        end

        // Literal gap length: valid-low cycles between an accepted last and the next SOP with en held.
        always @(negedge clk) begin
            if (!rstN || (en !== 1'b1)) begin
                armed  = 1'b0;
                lowRun = 0;
            end else begin
                if (armed && validO[g]) begin
                    checkOutput(g, "gap_len", 32'(lowRun), 32'(G));
                    armed = 1'b0;
                end else if (armed) begin
                    lowRun++;
                end
                if (validO[g] && ready && lastO[g]) begin
                    armed  = 1'b1;
                    lowRun = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic enV, input int readyPct, input int errOneIn,
                                 input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            en     = enV;
            ready  = (int'($urandom_range(99)) < readyPct);
            errInj = (errOneIn > 0) && ($urandom_range(errOneIn - 1) == 0);
        end
    endtask

    task automatic pulseErr(input int holdOff);
        @(posedge clk);
        #2;
        errInj = 1'b1;
        @(posedge clk);
        #2;
        errInj = 1'b0;
        repeat (holdOff) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic waitAccepts(input int n, input bit needSop, input int budget);
        int seen;
        int cyc;
        bit started;
        seen    = 0;
        cyc     = 0;
        started = !needSop;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            if (validO[0] && ready) begin
                if (!started && userO[0]) started = 1'b1;
                if (started) seen++;
            end
            cyc++;
        end
        checkOutput(0, "wait_accepts", 32'(seen), 32'(n));
        @(posedge clk);
        #2;
    endtask

    task automatic waitPackets(input int n, input int budget);
        int cyc;
        cyc = 0;
        while (pktCntO[0] < 32'(n) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(0, "wait_packets", pktCntO[0], 32'(n));
        @(posedge clk);
        #2;
    endtask

    task automatic checkFirstWord(input int budget);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!validO[0] && cyc < budget);
        checkOutput(0, "first_valid", 32'(validO[0]), 32'd1);
        checkOutput(0, "first_word", dataO[0], 32'h8FFF_FFFF);
        checkOutput(0, "first_user", 32'(userO[0]), 32'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        buildPrbs();
        checkOutput(0, "pin_word0", prbsWord[0], 32'h8FFF_FFFF);
        checkOutput(0, "pin_word1", prbsWord[1], 32'hC0FF_FFFF);

        #1 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        en    = 1'b1;
        ready = 1'b1;
        rstN  = 1'b1;
        checkFirstWord(10);

        // Clean run: ten full packets, then stop and confirm no eleventh starts.
        waitPackets(10, 3000);
        applyStimulus(1'b0, 100, 0, 300);
        checkOutput(0, "clean_pkt_cnt", pktCntO[0], 32'd10);

        // Backpressure with sporadic injection pulses, then drain.
        applyStimulus(1'b1, 50, 64, 2000);
        applyStimulus(1'b0, 100, 0, 400);

        // Drop en at beat 100: the packet completes and the FSM idles.
        applyStimulus(1'b1, 100, 0, 1);
        waitAccepts(100, 1'b1, 1500);
        en        = 1'b0;
        pktBefore = pktCntO[0];
        applyStimulus(1'b0, 100, 0, 300);
        checkOutput(0, "stop_pkt_cnt", pktCntO[0], pktBefore + 32'd1);
        checkOutput(0, "stop_idle", 32'(validO[0]), 32'd0);
        applyStimulus(1'b1, 100, 0, 300);

        // Injection: single pulse, back-to-back pulses, pulses two cycles apart.
        pulseErr(20);
        pulseErr(0);
        pulseErr(20);
        pulseErr(1);
        pulseErr(20);

        // Reset at beat 50 of a packet.
        waitAccepts(50, 1'b1, 1500);
        rstN = 1'b0;
        #1;
        checkOutput(0, "rst_now_valid", 32'(validO[0]), 32'd0);
        checkOutput(0, "rst_now_pkt_cnt", pktCntO[0], 32'd0);
        applyStimulus(1'b1, 100, 0, 2);
        rstN = 1'b1;
        checkFirstWord(10);
        checkOutput(0, "post_rst_pkt_cnt", pktCntO[0], 32'd0);
        applyStimulus(1'b1, 100, 0, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/prbs_pkt_gen.md
# prbs_pkt_gen

Transmit-side PRBS31 packet source for link bring-up. Produces fixed-length packets of continuous, inverted PRBS31 data on a 32-bit valid/ready stream. Sits directly upstream of the transceiver TX user interface and is the traffic source whose stream `prbs_check` verifies end to end. The PRBS sequence runs continuously across packet boundaries. Packet length defaults to 256 words, matching the checker's length rule.

## Interface
- `PKT_WORDS`, 256: beats per packet, range 2..256.
- `IDLE_GAP`, 4: valid-low cycles between packets, range 0..255.
- `tx_user_clk_i` in 1: TX user clock; all logic in this domain.
- `tx_user_rst_n_i` in 1: reset, asynchronous, active-low.
- `en_i` in 1: level; 1 = generate packets; 0 = stop after current packet.
- `err_inject_i` in 1: pulse; corrupt one future beat.
- `tx_ready_i` in 1: downstream accept.
- `tx_data_o` out 32: PRBS payload.
- `tx_vldb_o` out 2: valid-byte mask.
- `tx_valid_o` out 1: beat valid.
- `tx_last_o` out 1: final beat of packet.
- `tx_user_o` out 1: first beat of packet (SOP).
- `pkt_cnt_o` out 32: packets completed, i.e. last beats accepted.

## Operation
- **Handshake:** a beat is accepted when `tx_valid_o & tx_ready_i` (acc).
  - While `tx_valid_o=1 & tx_ready_i=0`, the data, vldb, last and user outputs hold stable.
  - `tx_valid_o` never drops without acceptance.
- **PRBS:**
  - Polynomial x^31+x^28+1, inverted output, 32 bits per word.
  - LFSR seed is all ones.
  - The LFSR advances exactly once per load event and never advances otherwise.
  - A load event is the prime cycle, or any acc.
- **FSM states:** PRIME, IDLE, SEND, GAP.
  - PRIME: the single cycle after reset release. Load the first word, then go to IDLE.
  - IDLE: `tx_valid_o=0`. When `en_i=1`, go to SEND, with `beat_cnt=0`.
  - SEND: `tx_valid_o=1`.
    - On each acc, `beat_cnt` increments.
    - On acc with `tx_last_o`: `pkt_cnt_o` increments (wraps at 2^32). Go to GAP if `IDLE_GAP>0`. Otherwise go to SEND if `en_i`, else IDLE.
  - GAP: count `IDLE_GAP` cycles with `tx_valid_o=0`. Then go to SEND if `en_i`, else IDLE.
- **Beat flags:**
  - `tx_last_o = (beat_cnt == PKT_WORDS-1)`.
  - `tx_user_o = (beat_cnt == 0)`.
  - `beat_cnt` is 8 bits.
- **`tx_vldb_o`:** 2'b11 whenever `tx_valid_o=1`, else 2'b00.
- **`en_i` deassert mid-packet:** the packet completes in full; there are no truncated packets.
- **Error inject:**
  - `err_inject_i` sets `inj_pend`.
  - At the next load event, `inj_cur<=inj_pend` and `inj_pend` clears.
  - `tx_data_o = prbs_word ^ {31'b0, inj_cur}`. Exactly one beat has bit 0 flipped.
  - The LFSR itself is not affected.
  - Pulses while `inj_pend=1` merge into one injection.
- **Reset mid-operation:**
  - All state returns to its reset value immediately.
  - The LFSR reseeds and a new PRIME follows.
  - A partial packet is abandoned.

## Timing
- **Reset values:**
  - `tx_valid_o`, `tx_last_o`, `tx_user_o`, `tx_vldb_o`, `pkt_cnt_o`: 0.
  - `tx_data_o`: 0 until PRIME completes.
  - FSM enters PRIME.
- **Start latency:** `en_i` sampled high in IDLE gives `tx_valid_o=1` on the next cycle.
- **Data latency:** zero-bubble. The next word is presented the cycle after acc, so back-to-back acceptance gives one beat per cycle.
- **Gap:** last acc at cycle t gives `tx_valid_o` low for cycles t+1..t+IDLE_GAP and high again at t+IDLE_GAP+1, provided `en_i=1`.
- **Counter:** `pkt_cnt_o` updates the cycle after the last acc.
- **Injection:** corruption appears on the first word loaded after the pulse is registered, at earliest 1 cycle after the pulse.

## Structure
- Shared package `prbs_pkg` holds:
  - `PRBS_POLY_LEN=31`, `PRBS_POLY_TAP=28`, `PRBS_NBITS=32`, `PRBS_INV=1`;
  - `VLDB_FULL=2'b11`;
  - the FSM state enum.
- Sub-module: `gtwizard_ultrascale_0_prbs_any` with `CHK_MODE=0`, `INV_PATTERN=1`, `POLY_LENGHT=31`, `POLY_TAP=28`, `NBITS=32`.
  - EN is driven by the load event.
  - RST is driven by `~tx_user_rst_n_i`.
  - Its registered DATA_OUT, XORed with the injection bit, is `tx_data_o`.
  - Same instance and parameters as the checker's peer, so the generator is bit-exact with it by construction.

## Test plan
- **Loopback clean:** reset, `en_i=1`, `tx_ready_i=1`, outputs looped into `prbs_check`.
  - 10 packets of 256 beats each.
  - `err_o=0`, `pkt_cnt_o=10`.
  - `tx_last_o` on beat 255 only; `tx_user_o` on beat 0 only.
- **Backpressure:** random `tx_ready_i` at 50%.
  - Outputs stable while stalled.
  - The accepted word sequence is identical to the clean run.
  - Checker `err_o=0`.
- **Gap:** `IDLE_GAP=4`.
  - Exactly 4 valid-low cycles between the last beat and the next SOP.
  - `IDLE_GAP=0` gives SOP on the cycle after last.
- **Stop mid-packet:** drop `en_i` at beat 100.
  - Packet runs to beat 255, then the FSM goes to IDLE.
  - `pkt_cnt_o` increments by 1.
  - Re-enabling continues the PRBS without error.
- **Inject:** one `err_inject_i` pulse, then two pulses 1 cycle apart.
  - Each case flips exactly one beat's bit 0.
  - Checker `err_o=1` (`r_err3` increments 1–2 times, per checker window).
  - Following beats are clean.
- **Reset mid-packet:** assert reset at beat 50 of packet 3.
  - All outputs 0 immediately.
  - After release: PRIME, then the first word equals the first word after power-on.
  - `pkt_cnt_o=0`.
